// File: rtl/rr_sel_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin mux-select arbiter.
// Imported by rr_pick and rr_sel_arbiter.
package rr_sel_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int BURST_MIN = 1;
    localparam int BURST_MAX = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        sel_onehot = NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit scanning from ptr upward, modulo NUM_CH.
// Purely combinational.
module rr_pick
    import rr_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    logic [SEL_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest request to ptr is written last and wins.
    always_comb begin
        idx    = ptr;
        found  = 1'b0;
        cand_s = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_s = ptr + SEL_W'(k);
            if (req[cand_s]) begin
                idx   = cand_s;
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin scheduler driving the select of a 4-to-1 data mux, with a valid/ready
// output handshake, per-channel burst limit and registered sel/grant/out_valid.
module rr_sel_arbiter
    import rr_sel_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic [NUM_CH-1:0] grant
);

    localparam int              CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    generate
        if (BURST < BURST_MIN || BURST > BURST_MAX) begin : g_burst_range
            $error("rr_sel_arbiter: BURST out of range 1..8");
        end
    endgenerate

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_CH-1:0]  grant_q;
    logic               out_valid_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [SEL_W-1:0]   pick_idx_s;
    logic               pick_found_s;
    logic               keep_s;
    logic               xfer_s;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Stay on the current channel while its burst allowance is not yet used up.
    assign keep_s = (cnt_q != '0) && (cnt_q < BURST_C) && req[sel_q];
    assign xfer_s = out_valid_q && out_ready;

    // Arbitration FSM with registered outputs and rotation/burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (keep_s) begin
                        grant_q     <= sel_onehot(sel_q);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_GRANT;
                    end else if (pick_found_s) begin
                        sel_q       <= pick_idx_s;
                        grant_q     <= sel_onehot(pick_idx_s);
                        ptr_q       <= pick_idx_s + SEL_W'(1);
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_GRANT;
                    end else begin
                        cnt_q       <= '0;
                        grant_q     <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (xfer_s) begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        grant_q     <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    grant_q     <= '0;
                    out_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = out_valid_q;

endmodule
